// File: rtl/lsu_bus_ctrl.sv
// Load/store bus controller: turns one byte-addressed request into one or two
// 8-byte-aligned beats on a valid/ready bus and returns right-aligned load data.
module lsu_bus_ctrl #(
  parameter int XLEN    = 64,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_wen,
  input  logic [1:0]      req_size,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err,
  output logic            bus_valid,
  input  logic            bus_ready,
  output logic            bus_wen,
  output logic [XLEN-1:0] bus_addr,
  output logic [XLEN-1:0] bus_wdata,
  output logic [7:0]      bus_wmask,
  input  logic            bus_rvalid,
  input  logic [XLEN-1:0] bus_rdata,
  input  logic            bus_err
);

  typedef enum logic [2:0] {IDLE, B0_REQ, B0_WAIT, B1_REQ, B1_WAIT, RESP} state_e;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic              wen_q, wen_d;
  logic [1:0]        size_q, size_d;
  logic [2:0]        off_q, off_d;
  logic [XLEN-1:0]   base_q, base_d;
  logic [15:0]       m16_q, m16_d;
  logic [2*XLEN-1:0] d128_q, d128_d;
  logic              split_q, split_d;
  logic [XLEN-1:0]   lo_q, lo_d;
  logic [XLEN-1:0]   hi_q, hi_d;
  logic              err_q, err_d;
  logic [7:0]        tcnt_q, tcnt_d;

  logic [3:0]        req_nbytes;
  logic [15:0]       req_ones;
  logic [2*XLEN-1:0] merged;
  logic [XLEN-1:0]   rmask;

  always_comb begin
    req_nbytes = 4'd1 << req_size;
    req_ones   = (16'd1 << req_nbytes) - 16'd1;
    merged     = {hi_q, lo_q} >> {off_q, 3'b000};
    // A shift of 64 yields zero, so a double-word access masks to all ones.
    rmask      = (XLEN'(1) << (7'd8 << size_q)) - XLEN'(1);
  end

  always_comb begin
    // NOTE: every signal gets a default first, so no path through this block infers a latch.
    state_d    = state_q;
    wen_d      = wen_q;
    size_d     = size_q;
    off_d      = off_q;
    base_d     = base_q;
    m16_d      = m16_q;
    d128_d     = d128_q;
    split_d    = split_q;
    lo_d       = lo_q;
    hi_d       = hi_q;
    err_d      = err_q;
    tcnt_d     = tcnt_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = '0;
    resp_err   = 1'b0;
    bus_valid  = 1'b0;
    bus_wen    = 1'b0;
    bus_addr   = '0;
    bus_wdata  = '0;
    bus_wmask  = '0;

    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          wen_d   = req_wen;
          size_d  = req_size;
          off_d   = req_addr[2:0];
          base_d  = {req_addr[XLEN-1:3], 3'b000};
          m16_d   = req_ones << req_addr[2:0];
          d128_d  = {{XLEN{1'b0}}, req_wdata} << {req_addr[2:0], 3'b000};
          split_d = ({1'b0, req_addr[2:0]} + req_nbytes) > 4'd8;
          err_d   = 1'b0;
          state_d = B0_REQ;
        end
      end
      B0_REQ: begin
        bus_valid = 1'b1;
        bus_wen   = wen_q;
        bus_addr  = base_q;
        bus_wdata = d128_q[XLEN-1:0];
        bus_wmask = wen_q ? m16_q[7:0] : 8'hFF;
        if (bus_ready) begin
          tcnt_d  = '0;
          state_d = B0_WAIT;
        end
      end
      B0_WAIT: begin
        if (bus_rvalid) begin
          lo_d = bus_rdata;
          if (bus_err) begin
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            state_d = split_q ? B1_REQ : RESP;
          end
        end else if (tcnt_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          tcnt_d = tcnt_q + 8'd1;
        end
      end
      B1_REQ: begin
        bus_valid = 1'b1;
        bus_wen   = wen_q;
        bus_addr  = base_q + XLEN'(8);
        bus_wdata = d128_q[2*XLEN-1:XLEN];
        bus_wmask = wen_q ? m16_q[15:8] : 8'hFF;
        if (bus_ready) begin
          tcnt_d  = '0;
          state_d = B1_WAIT;
        end
      end
      B1_WAIT: begin
        if (bus_rvalid) begin
          hi_d    = bus_rdata;
          err_d   = err_q | bus_err;
          state_d = RESP;
        end else if (tcnt_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          tcnt_d = tcnt_q + 8'd1;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        resp_rdata = wen_q ? '0 : (merged[XLEN-1:0] & rmask);
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      wen_q   <= 1'b0;
      size_q  <= '0;
      off_q   <= '0;
      base_q  <= '0;
      m16_q   <= '0;
      d128_q  <= '0;
      split_q <= 1'b0;
      lo_q    <= '0;
      hi_q    <= '0;
      err_q   <= 1'b0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wen_q   <= wen_d;
      size_q  <= size_d;
      off_q   <= off_d;
      base_q  <= base_d;
      m16_q   <= m16_d;
      d128_q  <= d128_d;
      split_q <= split_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      err_q   <= err_d;
      tcnt_q  <= tcnt_d;
    end
  end

endmodule
